clk_enable_sequencer: RTL

//  Runs in the single PLL output domain (51 MHz pixel/CPU clock) and gates start-up on PLL lock.

---
 rtl/clk_enable_sequencer_if.sv | 24 ++
 rtl/clk_enable_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_sequencer_if.sv
// clk_enable_sequencer_if: increment load bus and sequencer status outputs.
// The sequencer uses the slave modport; whoever programs the rates and consumes
// the enables/resets uses the master modport.
interface clk_enable_sequencer_if #(
    parameter int N_CH  = 3,
    parameter int ACC_W = 32
);
    logic [N_CH*ACC_W-1:0] inc_i;
    logic                  inc_load_i;
    logic [N_CH-1:0]       rst_o;
    logic [N_CH-1:0]       ce_o;
    logic                  ready_o;
    logic [7:0]            lock_loss_cnt_o;

    modport master (
        output inc_i, inc_load_i,
        input  rst_o, ce_o, ready_o, lock_loss_cnt_o
    );

    modport slave (
        input  inc_i, inc_load_i,
        output rst_o, ce_o, ready_o, lock_loss_cnt_o
    );
endinterface

// File: rtl/clk_enable_sequencer.sv
// clk_enable_sequencer: waits for a stable PLL lock, releases per-channel resets in
// index order, then produces fractional clock-enable strobes from phase accumulators.
// Optional macro CLK_SEQ_STATS_EN: when defined, lock_loss_cnt_o counts lock losses
// (saturating at 255); when undefined the counter is absent and the port reads 0.
module clk_enable_sequencer #(
    parameter int N_CH            = 3,
    parameter int ACC_W           = 32,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int STAGE_GAP_CYC   = 16
) (
    input  logic                  clk_i,
    input  logic                  reset,
    input  logic                  pll_locked_i,
    clk_enable_sequencer_if.slave bus
);
    localparam int STAB_W = $clog2(LOCK_STABLE_CYC + 1);
    localparam int GAP_W  = $clog2(STAGE_GAP_CYC + 1);
    localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } state_t;

    state_t            state;
    logic [1:0]        lock_sync;
    logic              locked_s;
    logic              lock_loss;
    logic [STAB_W-1:0] stab_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [IDX_W-1:0]  ch_idx;
    logic [N_CH-1:0]   rst_q;
    logic              ready_q;

    logic [ACC_W-1:0]  acc_q    [N_CH];
    logic [ACC_W-1:0]  shadow_q [N_CH];
    logic [ACC_W-1:0]  pend_q   [N_CH];
    logic [N_CH-1:0]   pend_v_q;
    logic [N_CH-1:0]   ce_q;

    logic [ACC_W-1:0]  pend_n   [N_CH];
    logic [N_CH-1:0]   pend_v_n;
    logic [ACC_W:0]    sum      [N_CH];
    logic [N_CH-1:0]   hold;

    assign locked_s  = lock_sync[1];
    // Lock is lost whenever the synchronised lock drops outside WAIT_LOCK.
    assign lock_loss = (state != WAIT_LOCK) && !locked_s;

    // Two-flop synchroniser for the asynchronous PLL lock; cleared by reset so the
    // post-reset lock timing is deterministic.
    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (reset) lock_sync <= 2'b00;
        else       lock_sync <= {lock_sync[0], pll_locked_i};
    end

    // Start-up sequencer: lock qualification, staged reset release, lock-loss recovery.
    always_ff @(posedge clk_i) begin
        if (reset || lock_loss) begin
            state    <= WAIT_LOCK;
            stab_cnt <= '0;
            gap_cnt  <= '0;
            ch_idx   <= '0;
            rst_q    <= '1;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state    <= STABLE;
                        stab_cnt <= '0;
                    end
                end
                STABLE: begin
                    if (stab_cnt == STAB_LAST) begin
                        rst_q[0] <= 1'b0;
                        gap_cnt  <= '0;
                        ch_idx   <= IDX_W'(1);
                        if (N_CH == 1) begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                        end else begin
                            state   <= RELEASE;
                        end
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt       <= '0;
                        rst_q[ch_idx] <= 1'b0;
                        ch_idx        <= ch_idx + 1'b1;
                        if (ch_idx == IDX_LAST) begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                RUN:     ready_q <= 1'b1;
                default: state   <= WAIT_LOCK;
            endcase
        end
    end

    // Next pending increment, accumulator sum and per-channel hold condition.
    // NOTE: every element is assigned on every pass, so no latch can be inferred.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            pend_n[k]   = bus.inc_load_i ? bus.inc_i[k*ACC_W +: ACC_W] : pend_q[k];
            pend_v_n[k] = bus.inc_load_i | pend_v_q[k];
            sum[k]      = {1'b0, acc_q[k]} + {1'b0, shadow_q[k]};
            hold[k]     = rst_q[k] | lock_loss;
        end
    end

    // Phase accumulators: strobe on carry, hand a pending increment over while held
    // in reset or on the carry cycle (that carry still uses the old increment).
    // NOTE: the accumulator/shadow arrays are a few flops, not a RAM, and must read
    // zero after reset, so they are reset explicitly.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) begin
                acc_q[k]    <= '0;
                shadow_q[k] <= '0;
                pend_q[k]   <= '0;
            end
            pend_v_q <= '0;
            ce_q     <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                pend_q[k]   <= pend_n[k];
                pend_v_q[k] <= pend_v_n[k];
                if (hold[k]) begin
                    acc_q[k] <= '0;
                    ce_q[k]  <= 1'b0;
                    if (pend_v_n[k]) begin
                        shadow_q[k] <= pend_n[k];
                        pend_v_q[k] <= 1'b0;
                    end
                end else begin
                    acc_q[k] <= sum[k][ACC_W-1:0];
                    ce_q[k]  <= sum[k][ACC_W];
                    if (sum[k][ACC_W] && pend_v_n[k]) begin
                        shadow_q[k] <= pend_n[k];
                        pend_v_q[k] <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef CLK_SEQ_STATS_EN
    logic [7:0] loss_cnt_q;

    // Saturating count of lock losses since the last reset.
    always_ff @(posedge clk_i) begin
        if (reset)                                loss_cnt_q <= 8'd0;
        else if (lock_loss && loss_cnt_q != 8'hFF) loss_cnt_q <= loss_cnt_q + 8'd1;
    end

    assign bus.lock_loss_cnt_o = loss_cnt_q;
`else
    assign bus.lock_loss_cnt_o = 8'd0;
`endif

    assign bus.rst_o   = rst_q;
    assign bus.ce_o    = ce_q;
    assign bus.ready_o = ready_q;
endmodule
